// File: rtl/fir_host_loader.sv
// Streams coefficient and sample words from a valid/ready source into the FIR core's
// register file, kicks off a run, and reports completion or timeout with the WAIT cycle count.
module fir_host_loader #(
    parameter int          NUM_TAPS    = 4,
    parameter logic [4:0]  COEF_BASE   = 5'd10,
    parameter logic [4:0]  SAMPLE_BASE = 5'd20,
    parameter int          TIMEOUT     = 1024
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [31:0] cfg_data_i,
    output logic        fir_rf_we_o,
    output logic [4:0]  fir_rf_waddr_o,
    output logic [31:0] fir_rf_wdata_o,
    output logic        fir_start_o,
    input  logic        fir_done_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timed_out_o,
    output logic [15:0] run_cycles_o
);

    localparam int                NWORDS     = 2 * NUM_TAPS;
    localparam int                WCNT_W     = (NWORDS > 2) ? $clog2(NWORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(NWORDS - 1);
    localparam logic [WCNT_W-1:0] TAPS_CNT   = WCNT_W'(NUM_TAPS);
    localparam logic [4:0]        TAPS_5     = 5'(NUM_TAPS);
    localparam logic [15:0]       WAIT_LIMIT = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic [15:0]       run_cycles_q, run_cycles_d;
    logic              timed_out_q, timed_out_d;
    logic              done_q;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;

    logic              handshake;
    logic              completion;
    logic [4:0]        wcnt_5;
    logic [4:0]        word_addr;
    logic [15:0]       wait_cnt_inc;

    assign handshake    = cfg_valid_i && (state_q == S_IDLE) && !reset_i;
    assign completion   = fir_done_i && !done_q;
    assign wcnt_5       = 5'(wcnt_q);
    // Both address sums wrap modulo 32 so a base near the top of the file rolls over to x0.
    assign word_addr    = (wcnt_q < TAPS_CNT) ? (COEF_BASE + wcnt_5)
                                              : (SAMPLE_BASE + (wcnt_5 - TAPS_5));
    assign wait_cnt_inc = (wait_cnt_q == 16'hFFFF) ? 16'hFFFF : (wait_cnt_q + 16'd1);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            wait_cnt_q   <= '0;
            run_cycles_q <= '0;
            timed_out_q  <= 1'b0;
            done_q       <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            wait_cnt_q   <= wait_cnt_d;
            run_cycles_q <= run_cycles_d;
            timed_out_q  <= timed_out_d;
            done_q       <= fir_done_i;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        wait_cnt_d   = wait_cnt_q;
        run_cycles_d = run_cycles_q;
        timed_out_d  = timed_out_q;

        // x0 is hard-wired in the core, so a word mapped there is counted but never written.
        rf_we_d      = handshake && (word_addr != 5'd0);
        rf_waddr_d   = handshake ? word_addr  : rf_waddr_q;
        rf_wdata_d   = handshake ? cfg_data_i : rf_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    if (wcnt_q == LAST_WORD) begin
                        state_d = S_DRAIN;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_START;
            end
            S_START: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_inc;
                // A core completion in the same cycle as the timeout takes priority.
                if (completion) begin
                    state_d      = S_DONE;
                    timed_out_d  = 1'b0;
                    run_cycles_d = wait_cnt_inc;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d      = S_DONE;
                    timed_out_d  = 1'b1;
                    run_cycles_d = wait_cnt_inc;
                end
            end
            S_DONE: begin
                wcnt_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cfg_ready_o    = (state_q == S_IDLE) && !reset_i;
        busy_o         = (state_q != S_IDLE);
        fir_start_o    = (state_q == S_START);
        done_o         = (state_q == S_DONE);
        timed_out_o    = (state_q == S_DONE) && timed_out_q;
        run_cycles_o   = run_cycles_q;
        fir_rf_we_o    = rf_we_q;
        fir_rf_waddr_o = rf_waddr_q;
        fir_rf_wdata_o = rf_wdata_q;
    end

endmodule
